// File: rtl/rom_msg_pkg.sv
// Shared types and constants for the ROM message sequencer.
// Segment bounds are fixed; the separator address default lives here too.
package rom_msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_NEXT
    } state_e;

    localparam int SEG_CNT          = 4;
    localparam int SEG_IDX_W        = 2;
    localparam int SEP_ADDR_DEFAULT = 47;

    function automatic int seg_first(input logic [SEG_IDX_W-1:0] idx);
        case (idx)
            2'd0:    return 0;
            2'd1:    return 9;
            2'd2:    return 15;
            default: return 29;
        endcase
    endfunction

    function automatic int seg_last(input logic [SEG_IDX_W-1:0] idx);
        case (idx)
            2'd0:    return 8;
            2'd1:    return 14;
            2'd2:    return 21;
            default: return 36;
        endcase
    endfunction

endpackage

// File: rtl/rom_seg_ptr.sv
// Segment index and ROM address counter for rom_msg_seq.
// Saturates at segment and message ends; never wraps back to address 0.
module rom_seg_ptr
    import rom_msg_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_next_seg,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_next_seg_addr,
    output logic              o_last_in_seg,
    output logic              o_last_seg
);

    logic [SEG_IDX_W-1:0] r_seg;
    logic [ADDR_W-1:0]    r_addr;

    assign o_addr          = r_addr;
    assign o_last_in_seg   = (r_addr == ADDR_W'(seg_last(r_seg)));
    assign o_last_seg      = (r_seg == SEG_IDX_W'(SEG_CNT - 1));
    assign o_next_seg_addr = ADDR_W'(seg_first(r_seg + 1'b1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_seg  <= '0;
            r_addr <= ADDR_W'(seg_first('0));
        end else if (i_next_seg && !o_last_seg) begin
            r_seg  <= r_seg + 1'b1;
            r_addr <= o_next_seg_addr;
        end else if (i_step && !o_last_in_seg) begin
            r_addr <= r_addr + 1'b1;
        end
    end

endmodule

// File: rtl/rom_msg_seq.sv
// Reads a four-segment message from an external synchronous ROM and hands it out
// one character at a time over a valid/ready port. Define ROM_SEQ_SEP_EN to insert a separator.
module rom_msg_seq
    import rom_msg_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int SEP_ADDR = SEP_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_d,
    output logic [DATA_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_char;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_next_seg_addr;
    logic              w_last_in_seg;
    logic              w_last_seg;
    logic              w_sep_due;
    logic              w_in_next;

    assign rom_addr   = r_rom_addr;
    assign char_out   = r_char;
    assign char_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

    assign w_in_next = (r_state == ST_NEXT) && !abort;

    rom_seg_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_load          ((r_state == ST_IDLE) || abort),
        .i_step          (w_in_next && !w_last_in_seg),
        .i_next_seg      (w_in_next && w_last_in_seg && !w_last_seg && !w_sep_due),
        .o_addr          (w_addr),
        .o_next_seg_addr (w_next_seg_addr),
        .o_last_in_seg   (w_last_in_seg),
        .o_last_seg      (w_last_seg)
    );

`ifdef ROM_SEQ_SEP_EN
    // Set while the separator for the current segment end has been issued.
    logic r_sep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sep <= 1'b0;
        end else if ((r_state == ST_IDLE) || abort) begin
            r_sep <= 1'b0;
        end else if (w_in_next && w_last_in_seg && !w_last_seg) begin
            r_sep <= !r_sep;
        end
    end

    assign w_sep_due = !r_sep;
`else
    assign w_sep_due = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_char     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= ST_RD;
                            r_rom_addr <= ADDR_W'(seg_first('0));
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_RD: r_state <= ST_CAP;
                    ST_CAP: begin
                        r_char  <= rom_d;
                        r_valid <= 1'b1;
                        r_state <= ST_OUT;
                    end
                    ST_OUT: begin
                        if (char_ready) begin
                            r_valid <= 1'b0;
                            r_state <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (!w_last_in_seg) begin
                            r_rom_addr <= w_addr + 1'b1;
                            r_state    <= ST_RD;
                        end else if (w_last_seg) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_sep_due) begin
                            r_rom_addr <= ADDR_W'(SEP_ADDR);
                            r_state    <= ST_RD;
                        end else begin
                            r_rom_addr <= w_next_seg_addr;
                            r_state    <= ST_RD;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_msg_seq.sv
// Randomized self-checking bench for rom_msg_seq against a list-based message model.
// Build with or without ROM_SEQ_SEP_EN; the expected message follows the same macro.
module tb_rom_msg_seq;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int SEP_ADDR = 47;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              char_ready = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_d;
    logic [DATA_W-1:0] char_out;
    logic              char_valid;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rom_mem [2**ADDR_W];
    int                exp_addr[$];
    int                seg_lo [4] = '{0, 9, 15, 29};
    int                seg_hi [4] = '{8, 14, 21, 36};
    int                n_checks = 0;
    int                n_fail = 0;

    rom_msg_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SEP_ADDR (SEP_ADDR)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_d      (rom_d),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the sampled address appears after the edge.
    always @(posedge clk) rom_d <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rom_addr"}, rom_addr, 0);
        check({tag, ".char_out"}, char_out, 0);
        check({tag, ".char_valid"}, char_valid, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
    endtask

    // One message from a start pulse. Inputs change and outputs are sampled at negedges;
    // cyc counts negedges after the edge that sampled start.
    task automatic run_msg(input string name, input int stall_pct, input int hold_char,
                           input int abort_char, input int restart_cyc, input int reset_cyc);
        int               k = 0;
        int               cyc = 1;
        int               n = exp_addr.size();
        int               n_done = 0;
        int               first_v = -1;
        int               last_acc = -1;
        int               done_cyc = -1;
        int               hold_left = 0;
        bit               hold_used = 1'b0;
        bit               prev_wait = 1'b0;
        bit               ended = 1'b0;
        bit               saw_sep = 1'b0;
        bit               timed;
        logic [DATA_W-1:0] prev_char = '0;

        timed = (stall_pct == 0) && (hold_char < 0) && (abort_char < 0) && (reset_cyc < 0);
        char_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!ended && cyc < 800) begin
            if (char_valid && first_v < 0) first_v = cyc;
            if (busy && rom_addr == ADDR_W'(SEP_ADDR)) saw_sep = 1'b1;
            if (prev_wait) begin
                check($sformatf("%s.stall_valid%0d", name, k), char_valid, 1);
                check($sformatf("%s.stall_char%0d", name, k), char_out, prev_char);
            end
            prev_wait = 1'b0;

            if (done) begin
                n_done++;
                done_cyc = cyc;
                ended = 1'b1;
                check({name, ".done_busy"}, busy, 0);
                check({name, ".count"}, k, n);
            end else if (cyc == reset_cyc) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero({name, ".async_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (done) n_done++;
                end
                check({name, ".rst_no_done"}, n_done, 0);
                check({name, ".rst_busy"}, busy, 0);
                ended = 1'b1;
            end else begin
                char_ready = ($urandom_range(0, 99) >= stall_pct);
                if (char_valid && k == hold_char && !hold_used) begin
                    hold_used = 1'b1;
                    hold_left = 5;
                end
                if (hold_left > 0) begin
                    char_ready = 1'b0;
                    hold_left--;
                end
                start = (cyc == restart_cyc);
                if (char_valid && k == abort_char) begin
                    abort = 1'b1;
                    char_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    char_ready = 1'b0;
                    check({name, ".abort_valid"}, char_valid, 0);
                    check({name, ".abort_busy"}, busy, 0);
                    check({name, ".abort_done"}, done, 0);
                    repeat (8) begin
                        @(negedge clk);
                        if (done) n_done++;
                    end
                    check({name, ".abort_no_done"}, n_done, 0);
                    ended = 1'b1;
                end else begin
                    if (char_valid && char_ready) begin
                        if (k < n) begin
                            check($sformatf("%s.char%0d", name, k), char_out, rom_mem[exp_addr[k]]);
                            check($sformatf("%s.addr%0d", name, k), rom_addr, exp_addr[k]);
                        end else begin
                            check($sformatf("%s.extra_char%0d", name, k), k, n);
                        end
                        last_acc = cyc;
                        k++;
                    end else if (char_valid) begin
                        prev_wait = 1'b1;
                        prev_char = char_out;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        start = 1'b0;
        char_ready = 1'b0;
        abort = 1'b0;
        check({name, ".finished"}, ended, 1);

        if (abort_char < 0 && reset_cyc < 0) begin
            repeat (5) begin
                @(negedge clk);
                if (done) n_done++;
            end
            check({name, ".done_once"}, n_done, 1);
            check({name, ".busy_after"}, busy, 0);
`ifndef ROM_SEQ_SEP_EN
            check({name, ".no_sep_addr"}, saw_sep, 0);
`endif
            if (timed) begin
                check({name, ".first_valid_cyc"}, first_v, 3);
                check({name, ".last_accept_cyc"}, last_acc, 3 + 4 * (n - 1));
                check({name, ".done_cyc"}, done_cyc, 3 + 4 * (n - 1) + 2);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        foreach (rom_mem[i]) rom_mem[i] = DATA_W'($urandom);
        for (int s = 0; s < 4; s++) begin
            for (int a = seg_lo[s]; a <= seg_hi[s]; a++) exp_addr.push_back(a);
`ifdef ROM_SEQ_SEP_EN
            if (s < 3) exp_addr.push_back(SEP_ADDR);
`endif
        end

        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        run_msg("full", 0, -1, -1, -1, -1);
        run_msg("hold", 0, 2, -1, -1, -1);
        run_msg("rand40", 40, -1, -1, -1, -1);
        run_msg("abort", 0, -1, 9, -1, -1);
        run_msg("after_abort", 0, -1, -1, -1, -1);
        run_msg("restart_reset", 0, -1, -1, 6, 30);
        run_msg("after_reset", 25, -1, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
